// File: rtl/fp16_mul_arbiter_if.sv
// Requester and shared-multiplier bus for fp16_mul_arbiter.
// The slave side is the arbiter; the master side is whoever drives requests
// and models the multiplier.
interface fp16_mul_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req_valid_50;
   logic [16*NREQ-1:0]   req_x_50;
   logic [16*NREQ-1:0]   req_y_50;
   logic [NREQ-1:0]      req_ready_50;
   logic [15:0]          mul_x_50;
   logic [15:0]          mul_y_50;
   logic [15:0]          mul_z_50;
   logic [NREQ-1:0]      rsp_valid_50;
   logic [15:0]          rsp_data_50;

   modport slave (
      input  req_valid_50, req_x_50, req_y_50, mul_z_50,
      output req_ready_50, mul_x_50, mul_y_50, rsp_valid_50, rsp_data_50
   );

   modport master (
      output req_valid_50, req_x_50, req_y_50, mul_z_50,
      input  req_ready_50, mul_x_50, mul_y_50, rsp_valid_50, rsp_data_50
   );
endinterface

// File: rtl/fp16_mul_arbiter.sv
// Arbiter sharing one pipelined fp16 multiplier (latency LAT) among NREQ
// requesters, with flush/drain sequencing and an issue counter.
// Build option: define FP16_ARB_FIXED_PRIO_EN for fixed priority (requester 0
// highest, no round-robin pointer); default build is round-robin.
//
// state | meaning
// IDLE  | nothing requested; responses of earlier issues may still retire
// RUN   | granting one requester per cycle
// DRAIN | flush seen; no new grants, waiting for the tag pipe to empty
// DONE  | drain complete; flush_done_50 high for this one cycle
module fp16_mul_arbiter #(
   parameter int NREQ = 4,
   parameter int LAT  = 2
) (
   input  logic                 clk_50,
   input  logic                 reset_n_50,
   fp16_mul_arbiter_if.slave    bus,
   input  logic                 flush_50,
   output logic                 busy_50,
   output logic                 flush_done_50,
   output logic [15:0]          issue_cnt_50
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state;
   logic            grant_any;
   logic [IW-1:0]   grant_idx;
   logic            run_ok;
   logic            issue;
   logic [NREQ-1:0] ready;
   logic [LAT-1:0]  tag_v;
   logic [IW-1:0]   tag_id [LAT];
   logic [NREQ-1:0] rsp_onehot;
   logic [NREQ-1:0] rsp_valid;
   logic [15:0]     rsp_data;

`ifdef FP16_ARB_FIXED_PRIO_EN
   // Lowest-numbered valid requester wins (descending scan, last hit kept).
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid_50[k]) begin
            grant_any = 1'b1;
            grant_idx = IW'(k);
         end
      end
   end
`else
   logic [IW-1:0] rr_ptr;

   // First valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (bus.req_valid_50[(int'(rr_ptr) + k) % NREQ]) begin
            grant_any = 1'b1;
            grant_idx = IW'((int'(rr_ptr) + k) % NREQ);
         end
      end
   end

   // Pointer moves past the winner only when an operation actually issues.
   always_ff @(posedge clk_50 or negedge reset_n_50) begin
      if (!reset_n_50)
         rr_ptr <= '0;
      else if (issue)
         rr_ptr <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
   end
`endif

   assign run_ok = (state == RUN) && !flush_50;
   assign issue  = run_ok && grant_any;

   // One-hot grant, only while running and not being flushed.
   always_comb begin
      ready = '0;
      if (issue)
         ready[grant_idx] = 1'b1;
   end

   assign bus.req_ready_50 = ready;
   assign bus.mul_x_50     = issue ? bus.req_x_50[16*grant_idx +: 16] : 16'h0000;
   assign bus.mul_y_50     = issue ? bus.req_y_50[16*grant_idx +: 16] : 16'h0000;

   // Tag pipe tracks which requester owns each multiplier stage.
   always_ff @(posedge clk_50 or negedge reset_n_50) begin
      if (!reset_n_50) begin
         tag_v <= '0;
         for (int i = 0; i < LAT; i++)
            tag_id[i] <= '0;
      end else begin
         tag_v[0]  <= issue;
         tag_id[0] <= grant_idx;
         for (int i = 1; i < LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
         end
      end
   end

   // Decode the owner of the result leaving the multiplier.
   always_comb begin
      rsp_onehot = '0;
      rsp_onehot[tag_id[LAT-1]] = 1'b1;
   end

   // Capture the multiplier result and strobe its owner for one cycle.
   always_ff @(posedge clk_50 or negedge reset_n_50) begin
      if (!reset_n_50) begin
         rsp_valid <= '0;
         rsp_data  <= 16'h0000;
      end else begin
         rsp_valid <= tag_v[LAT-1] ? rsp_onehot : '0;
         if (tag_v[LAT-1])
            rsp_data <= bus.mul_z_50;
      end
   end

   assign bus.rsp_valid_50 = rsp_valid;
   assign bus.rsp_data_50  = rsp_data;

   // Sequencing FSM; flush_done_50 is registered alongside the state.
   always_ff @(posedge clk_50 or negedge reset_n_50) begin
      if (!reset_n_50) begin
         state         <= IDLE;
         flush_done_50 <= 1'b0;
      end else begin
         flush_done_50 <= 1'b0;
         case (state)
            IDLE: begin
               if (flush_50) begin
                  state         <= DONE;
                  flush_done_50 <= 1'b1;
               end else if (|bus.req_valid_50) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (flush_50)
                  state <= DRAIN;
               else if (!(|bus.req_valid_50) && !(|tag_v))
                  state <= IDLE;
            end
            DRAIN: begin
               if (!(|tag_v)) begin
                  state         <= DONE;
                  flush_done_50 <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Free-running count of issued operations, wraps naturally at 16 bits.
   always_ff @(posedge clk_50 or negedge reset_n_50) begin
      if (!reset_n_50)
         issue_cnt_50 <= 16'h0000;
      else if (issue)
         issue_cnt_50 <= issue_cnt_50 + 16'h0001;
   end

   assign busy_50 = (state != IDLE) || (|tag_v) || (|rsp_valid);

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a two-stage fp16 multiplier model.
module tb_fp16_mul_arbiter;
   localparam int NREQ = 4;
   localparam int LAT  = 2;

   logic        clk_50     = 1'b0;
   logic        reset_n_50 = 1'b0;
   logic        flush_50   = 1'b0;
   logic        busy_50;
   logic        flush_done_50;
   logic [15:0] issue_cnt_50;

   int total = 0;
   int bad   = 0;

   fp16_mul_arbiter_if #(.NREQ(NREQ)) bus ();

   fp16_mul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk_50        (clk_50),
      .reset_n_50    (reset_n_50),
      .bus           (bus),
      .flush_50      (flush_50),
      .busy_50       (busy_50),
      .flush_done_50 (flush_done_50),
      .issue_cnt_50  (issue_cnt_50)
   );

   always #5 clk_50 = ~clk_50;

   // Truncating fp16 multiply, normal operands only.
   function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
      logic [21:0] p;
      int          e;
      logic        s;
      s = a[15] ^ b[15];
      p = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
      e = int'(a[14:10]) + int'(b[14:10]) - 15;
      if (p[21]) begin
         e = e + 1;
         return {s, e[4:0], p[20:11]};
      end
      return {s, e[4:0], p[19:10]};
   endfunction

   logic [15:0] p1 = 16'h0000;
   logic [15:0] p2 = 16'h0000;

   // Multiplier model: result visible LAT cycles after the issue cycle.
   always @(posedge clk_50) begin
      p1 <= fmul(bus.mul_x_50, bus.mul_y_50);
      p2 <= p1;
   end
   assign bus.mul_z_50 = p2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_50);
      #1;
   endtask

   task automatic set_ops(input int i, input logic [15:0] x, input logic [15:0] y);
      bus.req_x_50[16*i +: 16] = x;
      bus.req_y_50[16*i +: 16] = y;
   endtask

   logic [15:0] yv [4];
   int          ord [8];
   int          n;

   initial begin
      bus.req_valid_50 = '0;
      bus.req_x_50     = '0;
      bus.req_y_50     = '0;
      yv[0] = 16'h3C00; yv[1] = 16'h4000; yv[2] = 16'h4200; yv[3] = 16'h4400;
      for (int k = 0; k < 8; k++) begin
`ifdef FP16_ARB_FIXED_PRIO_EN
         ord[k] = 0;
`else
         ord[k] = k % 4;
`endif
      end

      // Reset state
      #12;
      chk("rst_ready", 32'(bus.req_ready_50), 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid_50), 32'h0);
      chk("rst_rsp_data", 32'(bus.rsp_data_50), 32'h0);
      chk("rst_busy", 32'(busy_50), 32'h0);
      chk("rst_cnt", 32'(issue_cnt_50), 32'h0);
      chk("rst_flush_done", 32'(flush_done_50), 32'h0);
      tick();
      reset_n_50 = 1'b1;

      // Single request: 1.0 * 2.0 from requester 0
      set_ops(0, 16'h3C00, 16'h4000);
      bus.req_valid_50 = 4'b0001;
      tick();
      chk("s_ready", 32'(bus.req_ready_50), 32'h1);
      chk("s_mul_x", 32'(bus.mul_x_50), 32'h3C00);
      chk("s_mul_y", 32'(bus.mul_y_50), 32'h4000);
      tick();
      bus.req_valid_50 = 4'b0000;
      #1;
      chk("s_cnt", 32'(issue_cnt_50), 32'h1);
      chk("s_mul_x_idle", 32'(bus.mul_x_50), 32'h0);
      tick();
      chk("s_rsp_early", 32'(bus.rsp_valid_50), 32'h0);
      tick();
      chk("s_rsp_valid", 32'(bus.rsp_valid_50), 32'h1);
      chk("s_rsp_data", 32'(bus.rsp_data_50), 32'h4000);
      tick();
      chk("s_rsp_clear", 32'(bus.rsp_valid_50), 32'h0);
      chk("s_busy_idle", 32'(busy_50), 32'h0);

      // All four requesters valid for 8 cycles, starting from pointer 0
      reset_n_50 = 1'b0;
      tick();
      reset_n_50 = 1'b1;
      for (int i = 0; i < 4; i++) set_ops(i, 16'h3C00, yv[i]);
      bus.req_valid_50 = 4'b1111;
      tick();
      for (int k = 0; k < 12; k++) begin
         if (k == 8) bus.req_valid_50 = 4'b0000;
         #1;
         if (k < 8)
            chk($sformatf("rr_grant_%0d", k), 32'(bus.req_ready_50), 32'(4'b0001 << ord[k]));
         else
            chk($sformatf("rr_grant_%0d", k), 32'(bus.req_ready_50), 32'h0);
         if (k >= 3 && k <= 10) begin
            chk($sformatf("rr_rsp_%0d", k), 32'(bus.rsp_valid_50), 32'(4'b0001 << ord[k-3]));
            chk($sformatf("rr_data_%0d", k), 32'(bus.rsp_data_50), 32'(yv[ord[k-3]]));
         end else begin
            chk($sformatf("rr_rsp_%0d", k), 32'(bus.rsp_valid_50), 32'h0);
         end
         tick();
      end
      chk("rr_cnt", 32'(issue_cnt_50), 32'd8);

      // Two back-to-back issues, then flush
      set_ops(0, 16'h3E00, 16'h4000);
      set_ops(1, 16'h3800, 16'h4400);
      bus.req_valid_50 = 4'b0011;
      tick();
      chk("f_grant0", 32'(bus.req_ready_50), 32'h1);
      tick();
      bus.req_valid_50 = 4'b0010;
      #1;
      chk("f_grant1", 32'(bus.req_ready_50), 32'h2);
      tick();
      bus.req_valid_50 = 4'b0011;
      flush_50 = 1'b1;
      #1;
      chk("f_no_grant_flush", 32'(bus.req_ready_50), 32'h0);
      tick();
      flush_50 = 1'b0;
      #1;
      chk("f_no_grant_drain", 32'(bus.req_ready_50), 32'h0);
      chk("f_rsp0", 32'(bus.rsp_valid_50), 32'h1);
      chk("f_data0", 32'(bus.rsp_data_50), 32'h4200);
      chk("f_done_early", 32'(flush_done_50), 32'h0);
      tick();
      chk("f_rsp1", 32'(bus.rsp_valid_50), 32'h2);
      chk("f_data1", 32'(bus.rsp_data_50), 32'h4000);
      chk("f_done_early2", 32'(flush_done_50), 32'h0);
      tick();
      bus.req_valid_50 = 4'b0000;
      chk("f_done", 32'(flush_done_50), 32'h1);
      chk("f_rsp_none", 32'(bus.rsp_valid_50), 32'h0);
      chk("f_ready_done", 32'(bus.req_ready_50), 32'h0);
      tick();
      chk("f_done_pulse", 32'(flush_done_50), 32'h0);
      chk("f_busy_idle", 32'(busy_50), 32'h0);
      chk("f_cnt", 32'(issue_cnt_50), 32'd10);

      // Flush from IDLE
      flush_50 = 1'b1;
      tick();
      flush_50 = 1'b0;
      chk("i_done", 32'(flush_done_50), 32'h1);
      chk("i_busy", 32'(busy_50), 32'h1);
      chk("i_ready", 32'(bus.req_ready_50), 32'h0);
      tick();
      chk("i_done_pulse", 32'(flush_done_50), 32'h0);
      chk("i_rsp", 32'(bus.rsp_valid_50), 32'h0);
      chk("i_busy_idle", 32'(busy_50), 32'h0);

      // Reset one cycle after an issue
      set_ops(2, 16'h3C00, 16'h4400);
      bus.req_valid_50 = 4'b0100;
      tick();
      chk("r_grant", 32'(bus.req_ready_50), 32'h4);
      tick();
      bus.req_valid_50 = 4'b0000;
      #2;
      reset_n_50 = 1'b0;
      #1;
      chk("r_ready", 32'(bus.req_ready_50), 32'h0);
      chk("r_busy", 32'(busy_50), 32'h0);
      chk("r_cnt", 32'(issue_cnt_50), 32'h0);
      chk("r_rsp_valid", 32'(bus.rsp_valid_50), 32'h0);
      chk("r_rsp_data", 32'(bus.rsp_data_50), 32'h0);
      chk("r_flush_done", 32'(flush_done_50), 32'h0);
      tick();
      tick();
      reset_n_50 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("r_after_rsp_%0d", k), 32'(bus.rsp_valid_50), 32'h0);
      end

      // Counter wrap
      set_ops(0, 16'h3C00, 16'h3C00);
      bus.req_valid_50 = 4'b0001;
      n = 0;
      while (issue_cnt_50 != 16'hFFFF && n < 70000) begin
         tick();
         n++;
      end
      chk("w_preset", 32'(issue_cnt_50), 32'hFFFF);
      tick();
      chk("w_wrap", 32'(issue_cnt_50), 32'h0);
      bus.req_valid_50 = 4'b0000;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
